// File: rtl/dds_seq_pkg.sv
// Shared types and default parameters for the DDS sample sequencer.
package dds_seq_pkg;

  localparam int unsigned AW_DEF          = 10;
  localparam int unsigned DIV_N_DEF       = 5000;
  localparam int unsigned ADC_TIMEOUT_DEF = 2000;
  localparam int unsigned ROM_LAT_DEF     = 1;

  typedef enum logic [2:0] {
    IDLE,
    ADC_REQ,
    ADC_WAIT,
    ACCUM,
    ROM_WAIT,
    DAC_WAIT,
    DAC_LOAD
  } state_t;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dds_tick_gen.sv
// Sample tick generator: counts 0..DIV_N-1 while enabled, held at 0 otherwise.
module dds_tick_gen
  import dds_seq_pkg::*;
#(
  parameter int unsigned DIV_N = DIV_N_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV_N);

  logic [CW-1:0] count;

  // Free-running divider, cleared whenever the loop is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == CW'(DIV_N - 1)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == CW'(DIV_N - 1));

endmodule

// File: rtl/dds_sample_sequencer.sv
// DDS sample loop sequencer: tick -> ADC request -> phase accumulate ->
// ROM wait -> DAC load. Define DDS_SEQ_OVERRUN_CNT_EN to add the
// saturating overrun_cnt output counting ticks dropped while busy.
module dds_sample_sequencer
  import dds_seq_pkg::*;
#(
  parameter int unsigned DIV_N       = DIV_N_DEF,
  parameter int unsigned ADC_TIMEOUT = ADC_TIMEOUT_DEF,
  parameter int unsigned ROM_LAT     = ROM_LAT_DEF,
  parameter int unsigned AW          = AW_DEF
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          enable,
  output logic          adc_start,
  input  logic          adc_valid,
  input  logic [AW-1:0] adc_data,
  output logic [AW-1:0] freq_word,
  output logic [AW-1:0] rom_addr,
  input  logic [AW-1:0] rom_data,
  output logic [AW-1:0] dac_data,
  output logic          dac_load,
  input  logic          dac_busy,
  output logic          tick,
  output logic          busy,
  output logic          timeout_err
`ifdef DDS_SEQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]    overrun_cnt
`endif
);

  // One counter serves both the ADC timeout and the ROM latency wait.
  localparam int unsigned WMAX = (ADC_TIMEOUT > ROM_LAT) ? ADC_TIMEOUT : ROM_LAT;
  localparam int unsigned WCW  = cnt_width(WMAX);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt;
  logic           wait_done;

  dds_tick_gen #(.DIV_N(DIV_N)) u_tick (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .enable(enable),
    .tick  (tick)
  );

  assign wait_done = (wait_cnt == WCW'(ADC_TIMEOUT - 1));
  assign busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    adc_start = 1'b0;
    dac_load  = 1'b0;
    case (state_q)
      IDLE:     if (tick) state_d = ADC_REQ;
      ADC_REQ: begin
        adc_start = 1'b1;
        state_d   = ADC_WAIT;
      end
      ADC_WAIT: if (adc_valid || wait_done) state_d = ACCUM;
      ACCUM:    state_d = ROM_WAIT;
      ROM_WAIT: if (wait_cnt == WCW'(ROM_LAT - 1)) state_d = DAC_WAIT;
      DAC_WAIT: if (!dac_busy) state_d = DAC_LOAD;
      DAC_LOAD: begin
        dac_load = 1'b1;
        state_d  = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Wait counter, frequency latch, phase accumulator and DAC sample register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt    <= '0;
      freq_word   <= '0;
      rom_addr    <= '0;
      dac_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        ADC_REQ, ACCUM:     wait_cnt <= '0;
        ADC_WAIT, ROM_WAIT: wait_cnt <= wait_cnt + WCW'(1);
        default:            ;
      endcase
      // A valid result on the timeout cycle still wins.
      if (state_q == ADC_WAIT) begin
        if (adc_valid)      freq_word   <= adc_data;
        else if (wait_done) timeout_err <= 1'b1;
      end
      if (state_q == ACCUM) rom_addr <= rom_addr + freq_word;
      if (state_q == DAC_WAIT && !dac_busy) dac_data <= rom_data;
    end
  end

`ifdef DDS_SEQ_OVERRUN_CNT_EN
  // Saturating count of ticks dropped because a sequence was in flight.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) overrun_cnt <= '0;
    else if (tick && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule
